// File: rtl/sw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sw_ctrl_pkg
//   Shared types and helpers for the stopwatch sequencer.
//   - sw_state_t : FSM state encoding (IDLE, RUN, SPLIT, STOP)
//   - BTN_*      : bit positions inside the 3-bit button event vector
//   - sw_evt_t   : the single event that acts in a given cycle
//   - sel_event  : priority select clear > start > lap (others dropped)
//   - to_bcd2    : constant helper, small integer -> two BCD digits
// -----------------------------------------------------------------------------
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SPLIT = 2'd2,
    STOP  = 2'd3
  } sw_state_t;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLR   = 2;

  typedef struct packed {
    logic start;
    logic lap;
    logic clr;
  } sw_evt_t;

  // Exactly one event survives per cycle; lower-priority bits are discarded,
  // never remembered for a later cycle.
  function automatic sw_evt_t sel_event(input logic [2:0] btn);
    sw_evt_t evt;
    evt.clr   = btn[BTN_CLR];
    evt.start = btn[BTN_START] & ~btn[BTN_CLR];
    evt.lap   = btn[BTN_LAP] & ~btn[BTN_START] & ~btn[BTN_CLR];
    return evt;
  endfunction

  // Only used in constant expressions (counter terminal values, 0..99).
  function automatic logic [7:0] to_bcd2(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/sw_ctrl_if.sv
// -----------------------------------------------------------------------------
// sw_ctrl_if
//   Button-event / display bundle between the stopwatch sequencer and its
//   surroundings (debouncer on one side, 7-segment driver on the other).
//   btn_evt   [2:0] one-cycle event pulses: [0] start/stop, [1] lap, [2] clear
//   disp_min  [7:0] BCD minutes 00-59
//   disp_sec  [7:0] BCD seconds 00-59
//   disp_cs   [7:0] BCD centiseconds 00-99
//   running         1 in RUN or SPLIT
//   frozen          1 in SPLIT (display held)
//   wrap            one-cycle pulse on 59:59.99 -> 00:00.00
//   modport master : event source / display consumer
//   modport slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface sw_ctrl_if;

  logic [2:0] btn_evt;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  logic       running;
  logic       frozen;
  logic       wrap;

  modport master (
    output btn_evt,
    input  disp_min, disp_sec, disp_cs, running, frozen, wrap
  );

  modport slave (
    input  btn_evt,
    output disp_min, disp_sec, disp_cs, running, frozen, wrap
  );

endinterface

// File: rtl/sw_ctrl_bcd_mod_cnt.sv
// -----------------------------------------------------------------------------
// bcd_mod_cnt
//   Two-digit BCD counter, 0 .. MOD-1 (MOD in 2..100), counted directly in BCD
//   so no binary-to-BCD conversion is ever needed.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_en     in   advance by one
//   i_clr    in   synchronous clear (wins over i_en)
//   o_q      out  [7:4] tens digit, [3:0] units digit
//   o_carry  out  i_en while at MOD-1 (combinational, feeds the next stage)
// -----------------------------------------------------------------------------
module bcd_mod_cnt
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned MOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [7:0] o_q,
  output logic       o_carry
);

  localparam logic [7:0] LAST = to_bcd2(MOD - 1);

  logic [7:0] r_q;
  logic       w_last;

  assign w_last = (r_q == LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_q <= '0;
      end else if (r_q[3:0] == 4'd9) begin
        r_q <= {r_q[7:4] + 4'd1, 4'd0};
      end else begin
        r_q <= {r_q[7:4], r_q[3:0] + 4'd1};
      end
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_en & w_last;

endmodule

// File: rtl/sw_ctrl.sv
// -----------------------------------------------------------------------------
// sw_ctrl
//   Stopwatch sequencer. Turns debounced button events into a 4-state FSM,
//   gates a CLK_HZ/TICK_HZ prescaler and keeps a BCD mm:ss.cc count with a
//   lap (held) register. All outputs are registered.
//   Parameters: CLK_HZ (system clock), TICK_HZ (count resolution);
//               DIV = CLK_HZ/TICK_HZ must be >= 2.
//   clk   in   system clock, posedge
//   rst   in   asynchronous active-high reset
//   bus   sw_ctrl_if.slave : btn_evt in; disp_min/sec/cs, running, frozen,
//                            wrap out
// -----------------------------------------------------------------------------
module sw_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic      clk,
  input  logic      rst,
  sw_ctrl_if.slave  bus
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  sw_evt_t          w_evt;
  sw_state_t        r_state;
  sw_state_t        w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic             w_run;
  logic             w_tick;
  logic             w_clear_all;

  logic [7:0]       w_cs;
  logic [7:0]       w_sec;
  logic [7:0]       w_min;
  logic             w_cs_carry;
  logic             w_sec_carry;
  logic             w_min_carry;
  logic [23:0]      w_count;

  logic [23:0]      r_held;
  logic [23:0]      r_disp;
  logic             r_running;
  logic             r_frozen;
  logic             r_wrap;

  assign w_evt = sel_event(bus.btn_evt);

  // Decisions below use the pre-edge state, so a tick coincident with an
  // event is still applied and a lap captures the pre-tick count.
  assign w_run       = (r_state == RUN) || (r_state == SPLIT);
  assign w_tick      = w_run && (r_pre == PRE_LAST);
  assign w_clear_all = (r_state == STOP) && w_evt.clr;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves the next state
    // unassigned, which would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_evt.start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_evt.start)    w_state_nxt = STOP;
        else if (w_evt.lap) w_state_nxt = SPLIT;
      end
      SPLIT: begin
        if (w_evt.start)    w_state_nxt = STOP;
        else if (w_evt.lap) w_state_nxt = RUN;
      end
      STOP: begin
        if (w_evt.clr)        w_state_nxt = IDLE;
        else if (w_evt.start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: holds its partial value while stopped so a resume loses nothing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_clear_all) begin
      r_pre <= '0;
    end else if (w_run) begin
      if (w_tick) r_pre <= '0;
      else        r_pre <= r_pre + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Time count: cs -> sec -> min ripple of enables, carries are same-cycle.
  // ---------------------------------------------------------------------------
  bcd_mod_cnt #(.MOD(100)) u_cs (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_tick),
    .i_clr   (w_clear_all),
    .o_q     (w_cs),
    .o_carry (w_cs_carry)
  );

  bcd_mod_cnt #(.MOD(60)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cs_carry),
    .i_clr   (w_clear_all),
    .o_q     (w_sec),
    .o_carry (w_sec_carry)
  );

  bcd_mod_cnt #(.MOD(60)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_sec_carry),
    .i_clr   (w_clear_all),
    .o_q     (w_min),
    .o_carry (w_min_carry)
  );

  assign w_count = {w_min, w_sec, w_cs};

  // ---------------------------------------------------------------------------
  // Lap register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held <= '0;
    end else if (w_clear_all) begin
      r_held <= '0;
    end else if ((r_state == RUN) && w_evt.lap) begin
      r_held <= w_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. The display mux keys off the state (not r_frozen) so the
  // held value appears in the same cycle frozen rises.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp    <= '0;
      r_running <= 1'b0;
      r_frozen  <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_disp    <= (r_state == SPLIT) ? r_held : w_count;
      r_running <= w_run;
      r_frozen  <= (r_state == SPLIT);
      r_wrap    <= w_min_carry;
    end
  end

  assign bus.disp_min = r_disp[23:16];
  assign bus.disp_sec = r_disp[15:8];
  assign bus.disp_cs  = r_disp[7:0];
  assign bus.running  = r_running;
  assign bus.frozen   = r_frozen;
  assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_sw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_ctrl
//   Directed bench for sw_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
//   Inputs change and outputs are sampled on the falling edge. Cycle numbers
//   in comments count rising edges from the start event of each phase: with a
//   fresh prescaler, a start sampled at edge P1 gives tick n at P(1+10n), and
//   the display shows that value one edge later.
// -----------------------------------------------------------------------------
module tb_sw_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  sw_ctrl_if bus ();

  sw_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] disp;
  assign disp = {bus.disp_min, bus.disp_sec, bus.disp_cs};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the event is sampled by the next rising edge.
  task automatic pulse(input logic [2:0] v);
    bus.btn_evt = v;
    @(negedge clk);
    bus.btn_evt = 3'b000;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%06h expected=%06h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.btn_evt = 3'b000;

    // ---------------- reset state ----------------
    step(2);
    check("rst_disp",    disp,               24'h000000);
    check("rst_flags",   {21'd0, bus.running, bus.frozen, bus.wrap}, 24'd0);
    step(1);
    rst = 1'b0;
    step(1);
    check("idle_disp",   disp,               24'h000000);
    check("idle_run",    {23'd0, bus.running}, 24'd0);

    // ---------------- 1: start, 250 clocks ----------------
    pulse(3'b001);                       // start at P1
    step(250);                           // N251: disp = tick 24
    check("t1_run",      {23'd0, bus.running}, 24'd1);
    check("t1_disp",     disp,               24'h000024);
    check("t1_wrap",     {23'd0, bus.wrap},  24'd0);
    check("t1_frozen",   {23'd0, bus.frozen}, 24'd0);

    // ---------------- 2: 1000 ticks, stop, resume ----------------
    step(9754);                          // N10005
    pulse(3'b001);                       // stop at P10006, prescaler holds 5
    step(1);                             // N10007
    check("t2_stop_run", {23'd0, bus.running}, 24'd0);
    check("t2_stop_disp", disp,              24'h001000);
    step(500);
    check("t2_hold_disp", disp,              24'h001000);
    check("t2_hold_run", {23'd0, bus.running}, 24'd0);
    pulse(3'b001);                       // resume at Pr; prescaler 6,7,8,9 then tick at Pr+5
    step(5);                             // Nr+5
    check("t2_res_pre",  disp,               24'h001000);
    check("t2_res_run",  {23'd0, bus.running}, 24'd1);
    step(1);                             // Nr+6
    check("t2_res_tick", disp,               24'h001001);

    // ---------------- 4a: stop, then 111 in STOP clears ----------------
    pulse(3'b001);                       // STOP
    pulse(3'b111);                       // clear wins, start dropped
    step(1);
    check("t4a_disp",    disp,               24'h000000);
    check("t4a_flags",   {21'd0, bus.running, bus.frozen, bus.wrap}, 24'd0);
    step(30);
    check("t4a_still",   disp,               24'h000000);
    check("t4a_idle",    {23'd0, bus.running}, 24'd0);

    // ---------------- 3: lap hold and release ----------------
    pulse(3'b001);                       // start at P1
    step(3079);                          // N3080
    pulse(3'b010);                       // lap at P3081, coincident with tick 308
    step(1);                             // N3082
    check("t3_frozen",   {23'd0, bus.frozen}, 24'd1);
    check("t3_held",     disp,               24'h000307);
    step(100);
    check("t3_held2",    disp,               24'h000307);
    check("t3_running",  {23'd0, bus.running}, 24'd1);
    step(1822);                          // N5004
    pulse(3'b010);                       // lap back at P5005
    check("t3_last_held", disp,              24'h000307);
    step(1);                             // N5006
    check("t3_live",     disp,               24'h000500);
    check("t3_unfrozen", {23'd0, bus.frozen}, 24'd0);

    // ---------------- 4b: 011 in RUN -> STOP only ----------------
    pulse(3'b011);                       // stop at P5007, prescaler holds 6
    step(1);
    check("t4b_flags",   {21'd0, bus.running, bus.frozen, bus.wrap}, 24'd0);
    check("t4b_disp",    disp,               24'h000500);
    step(20);
    check("t4b_still",   disp,               24'h000500);

    // ---------------- 5: wrap from 59:59.99 ----------------
    force dut.u_min.r_q = 8'h59;
    force dut.u_sec.r_q = 8'h59;
    force dut.u_cs.r_q  = 8'h99;
    #1;
    release dut.u_min.r_q;
    release dut.u_sec.r_q;
    release dut.u_cs.r_q;
    step(1);
    check("t5_preload",  disp,               24'h595999);
    pulse(3'b001);                       // resume at Ps; tick at Ps+4
    step(3);                             // Ns+3
    check("t5_pre_wrap", {23'd0, bus.wrap},  24'd0);
    step(1);                             // Ns+4
    check("t5_wrap_hi",  {23'd0, bus.wrap},  24'd1);
    check("t5_disp_end", disp,               24'h595999);
    step(1);                             // Ns+5
    check("t5_wrap_lo",  {23'd0, bus.wrap},  24'd0);
    check("t5_disp_zero", disp,              24'h000000);
    step(10);                            // Ns+15
    check("t5_continue", disp,               24'h000001);
    check("t5_no_rewrap", {23'd0, bus.wrap}, 24'd0);

    // ---------------- 6: async reset mid-run ----------------
    step(37);
    #2;
    rst         = 1'b1;
    bus.btn_evt = 3'b001;                // lost while in reset
    #1;
    check("t6_async_disp", disp,             24'h000000);
    check("t6_async_flags", {21'd0, bus.running, bus.frozen, bus.wrap}, 24'd0);
    step(3);
    bus.btn_evt = 3'b000;
    rst         = 1'b0;
    step(10);
    check("t6_post_idle", {23'd0, bus.running}, 24'd0);
    check("t6_post_disp", disp,              24'h000000);
    pulse(3'b001);                       // start at P1
    step(25);                            // N26: tick 2 shown
    check("t6_restart",  disp,               24'h000002);
    check("t6_running",  {23'd0, bus.running}, 24'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
